lr2_seq_ctrl: RTL and testbench
===============================

# lr2_seq_ctrl

Run-mode controller for the team's 4-bit up/down sequence generator (ports CLK, RST, CE, LOAD, DAT_I, UP). It owns the generator's CE/LOAD/DAT_I/UP inputs and sequences it through four modes: free-run up, free-run down, ping-pong between two bounds, and single-shot. A programmable prescaler sets the step rate. A shadow copy of the generator state drives the bound detection. It sits between the board-level control logic (buttons and switches) and the generator instance.

## Interface
- PRESC_W, 8: width of the step-rate divider.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  level-sampled request to begin a run; acted on only in IDLE.
- STOP  in  1  abort the run; return to IDLE.
- MODE  in  2  00 up-wrap, 01 down-wrap, 10 ping-pong, 11 single-shot up.
- LO  in  4  lower bound / start value.
- HI  in  4  upper bound / start value for down mode.
- DIV  in  PRESC_W  a step occurs every DIV+1 RUN cycles.
- GEN_CE  out  1  to generator CE; one-cycle step pulse.
- GEN_LOAD  out  1  to generator LOAD.
- GEN_DAT  out  4  to generator DAT_I.
- GEN_UP  out  1  to generator UP.
- CNT  out  4  shadow of the generator state.
- BUSY  out  1  high in LOAD and RUN.
- DONE  out  1  one-cycle pulse when a single-shot completes.
- ERR  out  1  one-cycle pulse when START is rejected.

## Operation
- States: IDLE, LOAD, RUN, FIN.
- All outputs are registered. There is no combinational path from any input to any output.
- IDLE, START=1, STOP=0:
  - MODE, LO, HI and DIV are latched into config registers.
  - If MODE=10 and LO>=HI, the start is rejected: ERR pulses and the block stays in IDLE.
  - Otherwise the block goes to LOAD.
- IDLE with START=1 and STOP=1: stays in IDLE; no ERR.
- LOAD (one cycle):
  - GEN_LOAD=1.
  - GEN_DAT=HI for mode 01, LO otherwise. CNT takes the same value.
  - DIR=1, except DIR=0 for mode 01.
  - Prescaler cleared. Next state RUN.
- RUN, prescaler:
  - The prescaler counts 0..DIV.
  - When prescaler==DIV: a tick occurs, prescaler returns to 0, GEN_CE=1 for that cycle.
  - On a tick, CNT steps ±1 mod 16 in the direction given by GEN_UP.
- GEN_UP per mode:
  - 00: 1.
  - 01: 0.
  - 10: DIR.
  - 11: 1.
- Mode 00/01: wrap F→0 and 0→F freely; the run does not end by itself.
- Mode 10, direction update after each tick:
  - New CNT==HI → DIR=0.
  - New CNT==LO → DIR=1.
  - Result: LO, LO+1…HI, HI-1…LO, repeating.
- Mode 11: a tick whose new CNT==HI moves to FIN. With LO==HI this takes 16 ticks, wrapping through F→0.
- FIN (one cycle): DONE=1, GEN_* idle. Next state IDLE. CNT holds its final value.
- STOP=1 in LOAD, RUN or FIN:
  - Next state is IDLE.
  - STOP has priority over a tick in the same cycle: no GEN_CE, CNT unchanged.
- START in LOAD, RUN or FIN: ignored. Config inputs are ignored outside IDLE.
- In IDLE: GEN_CE=0 and GEN_LOAD=0. GEN_DAT, GEN_UP and CNT hold their values.

## Timing
- Reset values:
  - State IDLE, prescaler 0, DIR=1.
  - GEN_CE=0, GEN_LOAD=0, GEN_DAT=0, GEN_UP=1.
  - CNT=0, BUSY=0, DONE=0, ERR=0.
- Reset mid-run: all outputs return to their reset values immediately (asynchronous).
- START sampled at edge 0:
  - GEN_LOAD high in cycle 1.
  - RUN from cycle 2.
  - First GEN_CE in cycle 2+DIV; subsequent steps every DIV+1 cycles.
- DIV=0: GEN_CE is high on every RUN cycle.
- The generator state equals CNT one cycle after each GEN_LOAD or GEN_CE.
- ERR and DONE are exactly one cycle wide.

## Structure
- Package lr2_seq_pkg holds:
  - State encoding: IDLE=0, LOAD=1, RUN=2, FIN=3.
  - Mode constants: MODE_UP, MODE_DOWN, MODE_PING, MODE_SHOT.
- Sub-module lr2_presc:
  - PRESC_W-bit divider with clear input, enable input, DIV input and tick output.
  - Instantiated once in lr2_seq_ctrl.
- Top-level integration wires GEN_* to one generator instance, driving its RST from the inverted RST_N.

## Test plan
- Mode 00, LO=E, DIV=0: GEN_LOAD in cycle 1 with GEN_DAT=E; CNT sequence E,F,0,1; GEN_CE high on every RUN cycle.
- Mode 01, HI=2, DIV=3: CNT sequence 2,1,0,F; GEN_CE pulses spaced 4 cycles apart, first in cycle 5; GEN_UP=0.
- Mode 10, LO=3, HI=5, DIV=0: CNT sequence 3,4,5,4,3,4; GEN_UP reads 1,1,0,0,1 on successive ticks.
- Mode 10 with LO=5, HI=5: ERR one-cycle pulse; BUSY stays 0.
- Mode 11, LO=7, HI=7, DIV=0: 16 ticks, then FIN with DONE=1, then IDLE with CNT=7.
- Tick and STOP in the same cycle: no GEN_CE, CNT unchanged, IDLE next cycle. Separately, RST_N low mid-RUN: every output returns to its reset value without waiting for a clock edge.

Source files
------------

// File: rtl/lr2_seq_pkg.sv
// lr2_seq_pkg: shared types and constants for the lr2 sequence controller.
//   state_t : controller state encoding (IDLE/LOAD/RUN/FIN)
//   MODE_*  : run-mode encodings as presented on the MODE input
//   step4() : one +/-1 step of the 4-bit generator, wrapping mod 16
package lr2_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_SHOT = 2'b11;

  function automatic logic [3:0] step4(input logic [3:0] v, input logic up);
    return up ? v + 4'd1 : v - 4'd1;
  endfunction

endpackage

// File: rtl/lr2_presc.sv
// lr2_presc: step-rate divider.
//   CLK, RST_N : clock, async active-low reset
//   clr        : force count to 0 (wins over en)
//   en         : count this cycle
//   div        : tick when count == div, so one tick per div+1 enabled cycles
//   tick       : combinational, qualified by en; the caller registers it
module lr2_presc #(
  parameter int PRESC_W = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/lr2_seq_ctrl.sv
// lr2_seq_ctrl: run-mode controller for the 4-bit up/down sequence generator.
//   CLK, RST_N        : clock, async active-low reset
//   START, STOP       : begin a run (IDLE only) / abort to IDLE
//   MODE, LO, HI, DIV : run config, latched when a start is accepted
//   GEN_CE/LOAD/DAT/UP: registered drive to the generator
//   CNT               : shadow of the generator state
//   BUSY, DONE, ERR   : status (DONE/ERR are one-cycle pulses)
// All outputs are registered. A step is decided at the clock edge that
// raises GEN_CE, and CNT moves on that same edge; the generator follows one
// edge later. Deciding the step at the edge that samples STOP is what lets
// STOP suppress a step without an input-to-output path.
module lr2_seq_ctrl
  import lr2_seq_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               STOP,
  input  logic [1:0]         MODE,
  input  logic [3:0]         LO,
  input  logic [3:0]         HI,
  input  logic [PRESC_W-1:0] DIV,
  output logic               GEN_CE,
  output logic               GEN_LOAD,
  output logic [3:0]         GEN_DAT,
  output logic               GEN_UP,
  output logic [3:0]         CNT,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  state_t             state, state_nxt;
  logic [1:0]         cfg_mode;
  logic [3:0]         cfg_lo, cfg_hi;
  logic [PRESC_W-1:0] cfg_div;
  logic               dir;

  logic               start_ok, reject, shot_done, presc_en, presc_clr, tick;
  logic               up_now;
  logic [3:0]         cnt_step, load_val;

  lr2_presc #(.PRESC_W(PRESC_W)) u_presc (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (presc_clr),
    .en    (presc_en),
    .div   (cfg_div),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    start_ok  = START && !STOP;
    reject    = (state == IDLE) && start_ok && (MODE == MODE_PING) && !(LO < HI);
    // The last single-shot step is the cycle whose GEN_CE lands CNT on HI;
    // that pulse must reach the generator, so FIN follows it.
    shot_done = (state == RUN) && (cfg_mode == MODE_SHOT) && GEN_CE && (CNT == cfg_hi);
    presc_clr = (state == IDLE);
    presc_en  = ((state == LOAD) || (state == RUN)) && !STOP && !shot_done;
    load_val  = (MODE == MODE_DOWN) ? HI : LO;
    case (cfg_mode)
      MODE_DOWN: up_now = 1'b0;
      MODE_PING: up_now = dir;
      default:   up_now = 1'b1;
    endcase
    cnt_step  = step4(CNT, up_now);

    case (state)
      IDLE: if (start_ok && !reject) state_nxt = LOAD;
      LOAD: state_nxt = STOP ? IDLE : RUN;
      RUN: begin
        if (STOP)           state_nxt = IDLE;
        else if (shot_done) state_nxt = FIN;
      end
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cfg_mode <= MODE_UP;
      cfg_lo   <= '0;
      cfg_hi   <= '0;
      cfg_div  <= '0;
      dir      <= 1'b1;
      GEN_CE   <= 1'b0;
      GEN_LOAD <= 1'b0;
      GEN_DAT  <= '0;
      GEN_UP   <= 1'b1;
      CNT      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      if (state == IDLE && start_ok) begin
        cfg_mode <= MODE;
        cfg_lo   <= LO;
        cfg_hi   <= HI;
        cfg_div  <= DIV;
      end
      GEN_CE   <= tick;
      GEN_LOAD <= (state_nxt == LOAD);
      BUSY     <= (state_nxt == LOAD) || (state_nxt == RUN);
      DONE     <= (state_nxt == FIN);
      ERR      <= reject;
      if (state == IDLE && state_nxt == LOAD) begin
        // MODE/LO/HI are read directly: the config registers load on this edge.
        GEN_DAT <= load_val;
        CNT     <= load_val;
        GEN_UP  <= (MODE != MODE_DOWN);
        dir     <= (MODE != MODE_DOWN);
      end else if (tick) begin
        CNT    <= cnt_step;
        GEN_UP <= up_now;
        if (cfg_mode == MODE_PING) begin
          if (cnt_step == cfg_hi)      dir <= 1'b0;
          else if (cnt_step == cfg_lo) dir <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lr2_seq_ctrl.sv
// tb_lr2_seq_ctrl: directed-vector bench for lr2_seq_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// "cycle n" is the interval following edge n-1, edge 0 being the edge that
// samples START.
module tb_lr2_seq_ctrl;
  import lr2_seq_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N, START, STOP;
  logic [1:0] MODE;
  logic [3:0] LO, HI;
  logic [7:0] DIV;
  logic       GEN_CE, GEN_LOAD, GEN_UP, BUSY, DONE, ERR;
  logic [3:0] GEN_DAT, CNT;

  int n_chk = 0;
  int n_err = 0;

  lr2_seq_ctrl #(.PRESC_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .MODE(MODE),
    .LO(LO), .HI(HI), .DIV(DIV), .GEN_CE(GEN_CE), .GEN_LOAD(GEN_LOAD),
    .GEN_DAT(GEN_DAT), .GEN_UP(GEN_UP), .CNT(CNT), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Present a start request for one edge; returns in cycle 1.
  task automatic start_run(input logic [1:0] m, input logic [3:0] lo,
                           input logic [3:0] hi, input logic [7:0] dv);
    MODE = m; LO = lo; HI = hi; DIV = dv; START = 1'b1;
    cyc();
    START = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ce"},   GEN_CE,   1'b0);
    chk({tag, "_load"}, GEN_LOAD, 1'b0);
    chk({tag, "_dat"},  GEN_DAT,  4'h0);
    chk({tag, "_up"},   GEN_UP,   1'b1);
    chk({tag, "_cnt"},  CNT,      4'h0);
    chk({tag, "_busy"}, BUSY,     1'b0);
    chk({tag, "_done"}, DONE,     1'b0);
    chk({tag, "_err"},  ERR,      1'b0);
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0;
    MODE = 2'b00; LO = 4'h0; HI = 4'h0; DIV = 8'd0;
    #12;
    chk_reset_vals("rst");
    cyc();
    RST_N = 1'b1;
    cyc();

    // Mode 00, LO=E, DIV=0: step every RUN cycle, wrap F->0.
    start_run(MODE_UP, 4'hE, 4'h3, 8'd0);
    chk("up_load", GEN_LOAD, 1'b1);
    chk("up_dat",  GEN_DAT,  4'hE);
    chk("up_cnt0", CNT,      4'hE);
    chk("up_busy", BUSY,     1'b1);
    chk("up_ce0",  GEN_CE,   1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("up_ce",  GEN_CE, 1'b1);
      chk("up_cnt", CNT,    4'(4'hF + k));
      chk("up_dir", GEN_UP, 1'b1);
    end
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    chk("up_stop_ce",   GEN_CE, 1'b0);
    chk("up_stop_cnt",  CNT,    4'h1);
    chk("up_stop_busy", BUSY,   1'b0);

    // Mode 01, HI=2, DIV=3: ticks in cycles 5, 9, 13.
    cyc();
    start_run(MODE_DOWN, 4'h0, 4'h2, 8'd3);
    chk("dn_load", GEN_LOAD, 1'b1);
    chk("dn_dat",  GEN_DAT,  4'h2);
    chk("dn_cnt0", CNT,      4'h2);
    chk("dn_up",   GEN_UP,   1'b0);
    for (int c = 2; c <= 13; c++) begin
      cyc();
      chk("dn_ce", GEN_CE, (c >= 5 && (c - 5) % 4 == 0));
      if (c >= 5 && (c - 5) % 4 == 0) begin
        chk("dn_cnt", CNT, 4'(4'd1 - 4'((c - 5) / 4)));
        chk("dn_up",  GEN_UP, 1'b0);
      end
    end
    cyc(); cyc(); cyc();
    chk("dn_ce16", GEN_CE, 1'b0);
    // Edge 16 would raise the next step; STOP on that edge must win.
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    chk("tkstop_ce",   GEN_CE, 1'b0);
    chk("tkstop_cnt",  CNT,    4'hF);
    chk("tkstop_busy", BUSY,   1'b0);
    cyc();
    chk("idle_ce",   GEN_CE, 1'b0);
    chk("idle_cnt",  CNT,    4'hF);
    chk("idle_up",   GEN_UP, 1'b0);
    chk("idle_dat",  GEN_DAT, 4'h2);

    // Mode 10, LO=3, HI=5, DIV=0: 3,4,5,4,3,4 with GEN_UP 1,1,0,0,1.
    start_run(MODE_PING, 4'h3, 4'h5, 8'd0);
    chk("pp_cnt0", CNT, 4'h3);
    for (int k = 0; k < 5; k++) begin
      logic [3:0] ecnt [5];
      logic       eup  [5];
      ecnt = '{4'h4, 4'h5, 4'h4, 4'h3, 4'h4};
      eup  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      cyc();
      chk("pp_ce",  GEN_CE, 1'b1);
      chk("pp_cnt", CNT,    ecnt[k]);
      chk("pp_up",  GEN_UP, eup[k]);
    end
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    chk("pp_stop_busy", BUSY, 1'b0);

    // Mode 10 with LO==HI is rejected.
    cyc();
    start_run(MODE_PING, 4'h5, 4'h5, 8'd0);
    chk("rej_err",  ERR,      1'b1);
    chk("rej_busy", BUSY,     1'b0);
    chk("rej_load", GEN_LOAD, 1'b0);
    cyc();
    chk("rej_err1",  ERR,  1'b0);
    chk("rej_busy1", BUSY, 1'b0);

    // START together with STOP: no run, no ERR.
    STOP = 1'b1;
    start_run(MODE_PING, 4'h5, 4'h5, 8'd0);
    STOP = 1'b0;
    chk("ss_err",  ERR,  1'b0);
    chk("ss_busy", BUSY, 1'b0);

    // Mode 11, LO=HI=7, DIV=0: 16 steps wrapping through F->0, then FIN.
    cyc();
    start_run(MODE_SHOT, 4'h7, 4'h7, 8'd0);
    chk("sh_cnt0", CNT, 4'h7);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("sh_ce",   GEN_CE, 1'b1);
      chk("sh_cnt",  CNT,    4'(4'h7 + k));
      chk("sh_done", DONE,   1'b0);
    end
    cyc();
    chk("fin_done", DONE,   1'b1);
    chk("fin_ce",   GEN_CE, 1'b0);
    chk("fin_busy", BUSY,   1'b0);
    chk("fin_cnt",  CNT,    4'h7);
    cyc();
    chk("post_done", DONE, 1'b0);
    chk("post_cnt",  CNT,  4'h7);
    chk("post_busy", BUSY, 1'b0);

    // Async reset mid-RUN while stepping every cycle.
    start_run(MODE_UP, 4'h9, 4'h0, 8'd0);
    cyc(); cyc();
    chk("pre_rst_ce",  GEN_CE, 1'b1);
    chk("pre_rst_cnt", CNT,    4'hB);
    #2;
    RST_N = 1'b0;
    #1;
    chk_reset_vals("arst");
    cyc();
    RST_N = 1'b1;
    cyc();
    chk("arst_idle_busy", BUSY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
